alu_issue_scheduler: RTL

//  Slot allocator and oldest-first issue selector for the 64-entry ALU reservation queue.

---
 rtl/alu_issue_scheduler_pkg.sv | 22 ++
 rtl/alu_sched_oldest_pick.sv | 46 ++++
 rtl/alu_issue_scheduler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_issue_scheduler_pkg.sv
// Shared sizes, types and the wrap-safe age compare for the ALU issue scheduler.
package alu_issue_scheduler_pkg;

   localparam int QUEUE_SIZE     = 64;
   localparam int SLOT_W         = 6;
   localparam int SEQ_W          = SLOT_W + 1;
   localparam int DISPATCH_LANES = 4;
   localparam int ISSUE_PORTS    = 2;

   typedef logic [SLOT_W-1:0] slot_t;
   typedef logic [SEQ_W-1:0]  seq_t;
   typedef logic [SLOT_W:0]   count_t;

   // a is older than b when (a - b) mod 2^SEQ_W has its top bit set; valid
   // because at most QUEUE_SIZE sequence numbers are live at once.
   function automatic logic seq_older(input seq_t a, input seq_t b);
      seq_t diff;
      diff = a - b;
      return diff[SEQ_W-1];
   endfunction

endpackage

// File: rtl/alu_sched_oldest_pick.sv
// Masked oldest-entry reduction tree: returns the oldest slot set in cand.
module alu_sched_oldest_pick
   import alu_issue_scheduler_pkg::*;
(
   input  logic [QUEUE_SIZE-1:0] cand,
   input  seq_t                  seq [QUEUE_SIZE],
   output logic                  found,
   output slot_t                 index
);

   // Pairwise tournament, one level per index bit; ties keep the lower index.
   always_comb begin
      logic  lvl_v   [SLOT_W+1][QUEUE_SIZE];
      slot_t lvl_idx [SLOT_W+1][QUEUE_SIZE];
      seq_t  lvl_seq [SLOT_W+1][QUEUE_SIZE];
      for (int l = 0; l <= SLOT_W; l++) begin
         for (int n = 0; n < QUEUE_SIZE; n++) begin
            lvl_v[l][n]   = 1'b0;
            lvl_idx[l][n] = '0;
            lvl_seq[l][n] = '0;
         end
      end
      for (int n = 0; n < QUEUE_SIZE; n++) begin
         lvl_v[0][n]   = cand[n];
         lvl_idx[0][n] = slot_t'(n);
         lvl_seq[0][n] = seq[n];
      end
      for (int l = 1; l <= SLOT_W; l++) begin
         for (int n = 0; n < (QUEUE_SIZE >> l); n++) begin
            if (lvl_v[l-1][2*n+1] &&
                (!lvl_v[l-1][2*n] || seq_older(lvl_seq[l-1][2*n+1], lvl_seq[l-1][2*n]))) begin
               lvl_v[l][n]   = 1'b1;
               lvl_idx[l][n] = lvl_idx[l-1][2*n+1];
               lvl_seq[l][n] = lvl_seq[l-1][2*n+1];
            end else begin
               lvl_v[l][n]   = lvl_v[l-1][2*n];
               lvl_idx[l][n] = lvl_idx[l-1][2*n];
               lvl_seq[l][n] = lvl_seq[l-1][2*n];
            end
         end
      end
      found = lvl_v[SLOT_W][0];
      index = lvl_idx[SLOT_W][0];
   end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Slot allocator and oldest-first dual-port issue selector for the ALU queue.
module alu_issue_scheduler
   import alu_issue_scheduler_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic [DISPATCH_LANES-1:0] dispatch_valid,
   output logic                      dispatch_ready,
   output logic [SLOT_W-1:0]         alloc_slot0,
   output logic [SLOT_W-1:0]         alloc_slot1,
   output logic [SLOT_W-1:0]         alloc_slot2,
   output logic [SLOT_W-1:0]         alloc_slot3,
   input  logic [QUEUE_SIZE-1:0]     slot_ready,
   input  logic                      alu_stall0,
   input  logic                      alu_stall1,
   output logic                      issue_valid0,
   output logic                      issue_valid1,
   output logic [SLOT_W-1:0]         issue_slot0,
   output logic [SLOT_W-1:0]         issue_slot1,
   output logic [SLOT_W:0]           free_count
);

   logic [QUEUE_SIZE-1:0] occ_r;
   seq_t                  seq_r [QUEUE_SIZE];
   seq_t                  next_seq_r;
   logic                  issue_valid0_r, issue_valid1_r;
   slot_t                 issue_slot0_r, issue_slot1_r;
   count_t                free_count_r;

   slot_t                 free_slot_s [DISPATCH_LANES];
   logic [1:0]            lane_rank_s [DISPATCH_LANES];
   slot_t                 alloc_slot_s [DISPATCH_LANES];
   logic [2:0]            req_count_s;
   logic                  dispatch_ready_s, alloc_fire_s;
   logic [QUEUE_SIZE-1:0] alloc_set_s, issue_clear_s, cand_s, cand1_s, p0_onehot_s;
   logic                  p0_found_s, p1_found_s;
   slot_t                 p0_index_s, p1_index_s;
   logic [ISSUE_PORTS-1:0] bind_valid_s;
   slot_t                 bind_slot_s [ISSUE_PORTS];
   count_t                alloc_n_s, issued_n_s;

   // First-four-free priority encoder over the registered occupancy.
   always_comb begin
      logic [2:0] taken;
      taken = 3'd0;
      for (int k = 0; k < DISPATCH_LANES; k++) free_slot_s[k] = '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         if (!occ_r[i] && (taken < 3'd4)) begin
            free_slot_s[taken[1:0]] = slot_t'(i);
            taken = taken + 3'd1;
         end else begin
            taken = taken;
         end
      end
   end

   // Rank each lane among the valid lanes and map it onto a free slot.
   always_comb begin
      logic [2:0] rank;
      rank = 3'd0;
      for (int k = 0; k < DISPATCH_LANES; k++) begin
         lane_rank_s[k]  = rank[1:0];
         alloc_slot_s[k] = free_slot_s[rank[1:0]];
         if (dispatch_valid[k]) rank = rank + 3'd1;
         else                   rank = rank;
      end
      req_count_s = rank;
   end

   assign dispatch_ready_s = (free_count_r >= count_t'(req_count_s));
   assign alloc_fire_s     = dispatch_ready_s && !flush && (|dispatch_valid);
   assign alloc_n_s        = alloc_fire_s ? count_t'(req_count_s) : count_t'(0);

   // Occupancy bits set by this cycle's allocation.
   always_comb begin
      alloc_set_s = '0;
      for (int k = 0; k < DISPATCH_LANES; k++) begin
         if (alloc_fire_s && dispatch_valid[k]) alloc_set_s[alloc_slot_s[k]] = 1'b1;
         else                                   alloc_set_s = alloc_set_s;
      end
   end

   assign cand_s      = occ_r & slot_ready;
   assign p0_onehot_s = {{(QUEUE_SIZE-1){1'b0}}, p0_found_s} << p0_index_s;
   assign cand1_s     = cand_s & ~p0_onehot_s;

   alu_sched_oldest_pick u_pick0 (
      .cand  (cand_s),
      .seq   (seq_r),
      .found (p0_found_s),
      .index (p0_index_s)
   );

   alu_sched_oldest_pick u_pick1 (
      .cand  (cand1_s),
      .seq   (seq_r),
      .found (p1_found_s),
      .index (p1_index_s)
   );

   // Bind picks to the non-stalled ports; P0 always takes the first free port.
   always_comb begin
      bind_valid_s   = '0;
      bind_slot_s[0] = p0_index_s;
      bind_slot_s[1] = p1_index_s;
      case ({alu_stall1, alu_stall0})
         2'b00: begin
            bind_valid_s = {p1_found_s, p0_found_s};
         end
         2'b01: begin
            bind_valid_s   = {p0_found_s, 1'b0};
            bind_slot_s[1] = p0_index_s;
         end
         2'b10: begin
            bind_valid_s = {1'b0, p0_found_s};
         end
         default: begin
            bind_valid_s = '0;
         end
      endcase
   end

   // Occupancy bits released by this cycle's issue.
   always_comb begin
      issue_clear_s = '0;
      for (int p = 0; p < ISSUE_PORTS; p++) begin
         if (bind_valid_s[p]) issue_clear_s[bind_slot_s[p]] = 1'b1;
         else                 issue_clear_s = issue_clear_s;
      end
   end

   assign issued_n_s = count_t'(bind_valid_s[0]) + count_t'(bind_valid_s[1]);

   // Scheduler state: occupancy, ages, sequence counter, issue registers, free count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r          <= '0;
         next_seq_r     <= '0;
         issue_valid0_r <= 1'b0;
         issue_valid1_r <= 1'b0;
         issue_slot0_r  <= '0;
         issue_slot1_r  <= '0;
         free_count_r   <= count_t'(QUEUE_SIZE);
         for (int i = 0; i < QUEUE_SIZE; i++) seq_r[i] <= '0;
      end else if (flush) begin
         occ_r          <= '0;
         next_seq_r     <= '0;
         issue_valid0_r <= 1'b0;
         issue_valid1_r <= 1'b0;
         free_count_r   <= count_t'(QUEUE_SIZE);
      end else begin
         occ_r          <= (occ_r | alloc_set_s) & ~issue_clear_s;
         next_seq_r     <= next_seq_r + seq_t'(alloc_n_s);
         issue_valid0_r <= bind_valid_s[0];
         issue_valid1_r <= bind_valid_s[1];
         if (bind_valid_s[0]) issue_slot0_r <= bind_slot_s[0];
         if (bind_valid_s[1]) issue_slot1_r <= bind_slot_s[1];
         free_count_r   <= free_count_r - alloc_n_s + issued_n_s;
         for (int k = 0; k < DISPATCH_LANES; k++) begin
            if (alloc_fire_s && dispatch_valid[k])
               seq_r[alloc_slot_s[k]] <= next_seq_r + seq_t'(lane_rank_s[k]);
         end
      end
   end

   assign dispatch_ready = dispatch_ready_s;
   assign alloc_slot0    = alloc_slot_s[0];
   assign alloc_slot1    = alloc_slot_s[1];
   assign alloc_slot2    = alloc_slot_s[2];
   assign alloc_slot3    = alloc_slot_s[3];
   assign issue_valid0   = issue_valid0_r;
   assign issue_valid1   = issue_valid1_r;
   assign issue_slot0    = issue_slot0_r;
   assign issue_slot1    = issue_slot1_r;
   assign free_count     = free_count_r;

endmodule
